// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR stage with a one-word prefetch buffer and req/ack instruction-memory port.
// Latency: IR loads in the acked cycle with zero-wait memory; ins_out follows on the next edge.
// Backpressure: stall_out holds the control unit while an IR load waits for the fetched word.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        il_in,
  input  logic [1:0]  ps_in,
  input  logic [15:0] ja_in,
  output logic [15:0] imem_addr_out,
  output logic        imem_req_out,
  input  logic [15:0] imem_data_in,
  input  logic        imem_ack_in,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
  output logic        stall_out,
  output logic [15:0] icount_out
);

  // S_REQ: request in flight for pc_q; S_VALID: buf_q holds the word at pc_q;
  // S_DRAIN: request in flight for an address the PC has already left.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] icount_q, icount_d;

  logic        pc_upd;
  logic        ack_in_req;
  logic        word_ready;
  logic        ir_load;
  logic [15:0] br_off;

  // A PC update always wins over an IR load issued in the same cycle.
  assign pc_upd     = (ps_in != 2'b00);
  assign ack_in_req = (state_q == S_REQ) && imem_ack_in;
  assign word_ready = (state_q == S_VALID) || ack_in_req;
  assign ir_load    = il_in && !pc_upd && word_ready;

  // Branch offset is split across the instruction word: {ir[8:6], ir[2:0]}, signed.
  assign br_off = {{10{ir_q[8]}}, ir_q[8:6], ir_q[2:0]};

  // Next PC from the control unit's select; branch is relative to the current PC.
  always_comb begin
    pc_d = pc_q;
    case (ps_in)
      2'b01:   pc_d = pc_q + 16'd1;
      2'b10:   pc_d = pc_q + br_off;
      2'b11:   pc_d = ja_in;
      default: pc_d = pc_q;
    endcase
  end

  // IR load either from the prefetch buffer or bypassed straight from the ack data.
  always_comb begin
    ir_d     = ir_q;
    icount_d = icount_q;
    if (ir_load) begin
      ir_d     = (state_q == S_VALID) ? buf_q : imem_data_in;
      icount_d = icount_q + 16'd1;
    end
  end

  // Next-state, prefetch buffer and request address. Requests always target the
  // post-update PC so a same-cycle PC change is never fetched stale.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_BOOT: begin
        state_d    = S_REQ;
        req_addr_d = pc_d;
      end
      S_REQ: begin
        if (imem_ack_in && !pc_upd) begin
          state_d = S_VALID;
          buf_d   = imem_data_in;
        end else if (imem_ack_in && pc_upd) begin
          // Word belongs to the old PC: drop it and ask again.
          state_d    = S_REQ;
          req_addr_d = pc_d;
        end else if (pc_upd) begin
          // Must still absorb the ack of the outstanding request.
          state_d = S_DRAIN;
        end
      end
      S_VALID: begin
        if (pc_upd) begin
          state_d    = S_REQ;
          req_addr_d = pc_d;
        end
      end
      S_DRAIN: begin
        if (imem_ack_in) begin
          state_d    = S_REQ;
          req_addr_d = pc_d;
        end
      end
      default: begin
        state_d    = S_BOOT;
        req_addr_d = pc_q;
      end
    endcase
  end

  // Outputs: request strobe from state only; stall is the one input-dependent output.
  always_comb begin
    imem_req_out = (state_q == S_REQ) || (state_q == S_DRAIN);
    stall_out    = il_in && !pc_upd && !word_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, IR, prefetch buffer, request address, load counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      buf_q      <= 16'h0000;
      req_addr_q <= RESET_PC;
      icount_q   <= 16'h0000;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      buf_q      <= buf_d;
      req_addr_q <= req_addr_d;
      icount_q   <= icount_d;
    end
  end

  assign imem_addr_out = req_addr_q;
  assign ins_out       = ir_q;
  assign pc_out        = pc_q;
  assign icount_out    = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors against fetch_unit with a configurable-wait memory model.
// Latency: memory acks after wait_cfg cycles of request (0 = same cycle).
// Backpressure: bench holds il_in and checks stall_out until the ack arrives.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        il_in;
  logic [1:0]  ps_in;
  logic [15:0] ja_in;
  logic [15:0] imem_addr_out;
  logic        imem_req_out;
  logic [15:0] imem_data_in;
  logic        imem_ack_in;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        stall_out;
  logic [15:0] icount_out;

  int n_vec = 0;
  int n_err = 0;
  int wait_cfg = 0;
  int wcnt;
  int n;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .il_in         (il_in),
    .ps_in         (ps_in),
    .ja_in         (ja_in),
    .imem_addr_out (imem_addr_out),
    .imem_req_out  (imem_req_out),
    .imem_data_in  (imem_data_in),
    .imem_ack_in   (imem_ack_in),
    .ins_out       (ins_out),
    .pc_out        (pc_out),
    .stall_out     (stall_out),
    .icount_out    (icount_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 0010 holds a branch word with offset -2.
  function automatic logic [15:0] memword(input logic [15:0] a);
    if (a == 16'h0010) return 16'h01C6;
    return a + 16'h1234;
  endfunction

  // One ack per request, wait_cfg cycles after the request first appears.
  assign imem_ack_in  = imem_req_out && (wcnt == wait_cfg);
  assign imem_data_in = imem_ack_in ? memword(imem_addr_out) : 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wcnt <= 0;
    else if (!imem_req_out || imem_ack_in) wcnt <= 0;
    else                                 wcnt <= wcnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    il_in = 1'b0;
    ps_in = 2'b00;
    ja_in = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc",     pc_out,       16'h0000);
    chk("rst_ins",    ins_out,      16'h0000);
    chk("rst_req",    imem_req_out, 1'b0);
    chk("rst_stall",  stall_out,    1'b0);
    chk("rst_icount", icount_out,   16'h0000);
    chk("rst_addr",   imem_addr_out, 16'h0000);
    rst_n = 1'b1;

    // First request one cycle after release, zero-wait bypass load.
    tick;
    chk("boot_req",  imem_req_out,  1'b1);
    chk("boot_addr", imem_addr_out, 16'h0000);
    il_in = 1'b1;
    #2;
    chk("zw_stall", stall_out, 1'b0);
    tick;
    il_in = 1'b0;
    chk("zw_ins",    ins_out,    16'h1234);
    chk("zw_icount", icount_out, 16'h0001);

    // Sequential stepping from 0005.
    ps_in = 2'b11; ja_in = 16'h0005;
    tick;
    ps_in = 2'b00;
    chk("jmp5_pc", pc_out, 16'h0005);
    for (int i = 0; i < 4; i++) begin
      ps_in = 2'b01;
      tick;
      chk("seq_pc",   pc_out,        16'h0006 + 16'(i));
      chk("seq_addr", imem_addr_out, 16'h0006 + 16'(i));
    end
    ps_in = 2'b00;

    // Branch by -2 from 0010 using the IR loaded from 0010.
    ps_in = 2'b11; ja_in = 16'h0010;
    tick;
    ps_in = 2'b00;
    il_in = 1'b1;
    tick;
    il_in = 1'b0;
    chk("br_ins",    ins_out,    16'h01C6);
    chk("br_icount", icount_out, 16'h0002);
    ps_in = 2'b10;
    tick;
    ps_in = 2'b00;
    chk("br_pc",   pc_out,        16'h000E);
    chk("br_addr", imem_addr_out, 16'h000E);

    // Increment wraps at FFFF.
    ps_in = 2'b11; ja_in = 16'hFFFF;
    tick;
    ps_in = 2'b01;
    tick;
    ps_in = 2'b00;
    chk("wrap_pc", pc_out, 16'h0000);

    // Three wait states with il_in held.
    wait_cfg = 3;
    il_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("ws_stall", stall_out, (k < 3) ? 1'b1 : 1'b0);
      tick;
    end
    il_in = 1'b0;
    chk("ws_ins",    ins_out,    16'h1234);
    chk("ws_icount", icount_out, 16'h0003);

    // Jump while the request for 0020 is outstanding.
    ps_in = 2'b11; ja_in = 16'h0020;
    tick;
    ps_in = 2'b00;
    chk("fl_req",  imem_req_out,  1'b1);
    chk("fl_addr", imem_addr_out, 16'h0020);
    ps_in = 2'b11; ja_in = 16'h0100;
    tick;
    ps_in = 2'b00;
    chk("fl_pc",        pc_out,        16'h0100);
    chk("fl_drain_addr", imem_addr_out, 16'h0020);
    chk("fl_drain_req", imem_req_out,  1'b1);
    n = 0;
    while (imem_addr_out != 16'h0100 && n < 10) begin
      tick;
      n++;
    end
    chk("fl_drain_cycles", n, 3);
    il_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("fl_stall", stall_out, (k < 3) ? 1'b1 : 1'b0);
      tick;
    end
    il_in = 1'b0;
    chk("fl_ins",    ins_out,    16'h1334);
    chk("fl_icount", icount_out, 16'h0004);

    // Reset asserted while a request is in flight.
    ps_in = 2'b11; ja_in = 16'h0040;
    tick;
    ps_in = 2'b00;
    chk("mr_req_before", imem_req_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req",    imem_req_out, 1'b0);
    chk("mr_pc",     pc_out,       16'h0000);
    chk("mr_ins",    ins_out,      16'h0000);
    chk("mr_icount", icount_out,   16'h0000);
    chk("mr_stall",  stall_out,    1'b0);
    wait_cfg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("mr_boot_req",  imem_req_out,  1'b1);
    chk("mr_boot_addr", imem_addr_out, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register stage sitting directly upstream of the control unit. It holds PC and IR, prefetches the instruction at PC from instruction memory over a req/ack handshake, and loads IR when the control unit asserts instruction-load. It applies the control unit's PC-select command: hold, increment, branch relative, or jump. It raises a stall when an instruction load cannot complete that cycle.

## Interface
- RESET_PC, 16'h0000, PC value after reset.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- il_in  in  1  instruction load from control unit; loads IR.
- ps_in  in  2  PC select: 00 hold, 01 PC+1, 10 PC+offset, 11 jump.
- ja_in  in  16  jump address, the register-file A bus.
- imem_addr_out  out  16  instruction memory address.
- imem_req_out  out  1  read request.
- imem_data_in  in  16  read data, valid only with imem_ack_in.
- imem_ack_in  in  1  one-cycle read acknowledge.
- ins_out  out  16  IR contents, to control unit ins_in.
- pc_out  out  16  current PC.
- stall_out  out  1  load pending. The top level freezes the control unit and the datapath while this is high.
- icount_out  out  16  count of IR loads, wraps.

## Operation
- Registers: pc_r, ir_r, buf_r (prefetched word), req_addr_r, icount_r, state.
- States: S_BOOT, S_REQ (request outstanding for pc_r), S_VALID (buf_r holds the word at pc_r), S_DRAIN (request outstanding for a stale address).
- Handshake:
  - imem_req_out = 1 in S_REQ and S_DRAIN.
  - imem_addr_out = req_addr_r, stable until ack.
  - Ack may arrive in the same cycle as req, or any later cycle.
  - Exactly one ack per request.
- Transitions:
  - S_BOOT → S_REQ unconditionally, with req_addr_r <= pc_r.
  - S_REQ, ack, no PC update → S_VALID, buf_r <= imem_data_in.
  - S_REQ, ack, PC update → S_REQ; data discarded; req_addr_r <= new PC.
  - S_REQ, no ack, PC update → S_DRAIN.
  - S_DRAIN, ack → S_REQ; data discarded; req_addr_r <= pc_r.
  - S_VALID, PC update → S_REQ; req_addr_r <= new PC.
- PC update occurs when ps_in != 00:
  - 01: pc_r+1.
  - 10: pc_r + sign-extend({ir_r[8:6], ir_r[2:0]}), a 6-bit two's complement offset, range -32..+31.
  - 11: ja_in.
  - All arithmetic is modulo 2^16. Branch is relative to the current instruction's address.
- IR load when il_in=1 and one of the following holds:
  - state is S_VALID: ir_r <= buf_r.
  - state is S_REQ with imem_ack_in=1 (bypass): ir_r <= imem_data_in; the state still moves to S_VALID.
- On every IR load, icount_r increments.
- stall_out = il_in and not (S_VALID, or S_REQ with ack). It is combinational.
- Loading IR does not change PC and does not invalidate buf_r.
- il_in and ps_in != 00 never occur in the same cycle. If they do, the PC update takes priority and the IR load is suppressed. stall_out is 0 in that cycle.
- Reset asserted mid-request abandons the request. The memory must tolerate the dropped request.

## Timing
- Reset values:
  - pc_r = RESET_PC, ir_r = 0, buf_r = 0, icount_r = 0, req_addr_r = RESET_PC.
  - state = S_BOOT.
  - imem_req_out = 0, stall_out = 0, ins_out = 0, pc_out = RESET_PC.
- First request is issued in the first cycle after reset release.
- Zero-wait memory (ack with req): fetch latency 1 cycle after the PC change. An IR load in S_REQ+ack completes with no stall.
- N-cycle ack: stall_out is high for each il_in cycle before the ack. ins_out updates the cycle after the load.
- A PC change in flight costs the remaining wait of the stale request plus a full new request.
- pc_out and ins_out are registered outputs. imem_req_out and imem_addr_out come from state and register only, with no input-to-output paths. stall_out is the only combinational output.

## Test plan
- Reset, zero-wait memory: after release, imem_req_out=1 at address 0000 one cycle later. il_in with ack and data 16'h1234 → ins_out=1234, stall_out=0, icount_out=1.
- Sequential: ps_in=01 four times from PC=0005 → pc_out=0009. Each step re-requests at the new address.
- Branch: PC=0010, ir_r[8:6]=111, ir_r[2:0]=110 (offset -2), ps_in=10 → pc_out=000E. With PC=FFFF, ps_in=01 → 0000 (wrap).
- Wait states: ack delayed 3 cycles, il_in held high → stall_out high for 3 cycles and low on the ack cycle. IR equals the acked data.
- Jump in flight: request to 0020 outstanding, ps_in=11 with ja_in=0100 → S_DRAIN. The ack for 0020 is discarded. The next request is at 0100, and IR later loads the 0100 word.
- Reset mid-request: rst_n low while imem_req_out=1 → all outputs immediately take their reset values. A fresh request goes to RESET_PC after release.
